// File: rtl/alu_req_arbiter_if.sv
// Request, ALU and response signal bundle of the shared-ALU arbiter.
// The slave modport is the arbiter's view; master is the client/ALU side.
interface alu_req_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [5*NREQ-1:0]  req_opcode;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic               alu_en;
  logic [4:0]         alu_opcode;
  logic [31:0]        alu_in1;
  logic [31:0]        alu_in2;
  logic [31:0]        alu_result;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [2:0]         rsp_id;
  logic [31:0]        rsp_result;
  logic               rsp_err;

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, alu_result, rsp_ready,
    output req_ready, alu_en, alu_opcode, alu_in1, alu_in2,
           rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport master (
    output req_valid, req_opcode, req_a, req_b, alu_result, rsp_ready,
    input  req_ready, alu_en, alu_opcode, alu_in1, alu_in2,
           rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU between NREQ requesters,
// with opcode-dependent execution length and a single backpressured response.
module alu_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input logic              clk,
  input logic              rst_n,
  alu_req_arbiter_if.slave bus
);
  localparam int IDW = 3;
  localparam int CW  = 8;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_r;
  logic [IDW-1:0]  rr_ptr_r;
  logic [CW-1:0]   cnt_r;
  logic [NREQ-1:0] req_ready_r;
  logic            alu_en_r;
  logic [4:0]      alu_opcode_r;
  logic [31:0]     alu_in1_r;
  logic [31:0]     alu_in2_r;
  logic            rsp_valid_r;
  logic [IDW-1:0]  rsp_id_r;
  logic [31:0]     rsp_result_r;
  logic            rsp_err_r;

  logic            grant_any_s;
  logic [IDW-1:0]  grant_idx_s;
  logic [NREQ-1:0] grant_onehot_s;
  logic [7:0]      valid8_s;
  logic [7:0]      oh8_s;
  logic [3:0]      cand_s;
  logic [4:0]      op_arr_s [8];
  logic [31:0]     a_arr_s  [8];
  logic [31:0]     b_arr_s  [8];
  logic [4:0]      sel_op_s;
  logic [31:0]     sel_a_s;
  logic [31:0]     sel_b_s;

  function automatic logic [CW-1:0] exec_cycles(input logic [4:0] op);
    logic [CW-1:0] c;
    case (op)
      5'd2:                    c = CW'(MUL_LAT - 1);
      5'd3, 5'd4, 5'd6, 5'd7:  c = CW'(DIV_LAT - 1);
      default:                 c = 8'd0;
    endcase
    return c;
  endfunction

  function automatic logic op_illegal(input logic [4:0] op);
    return (op > 5'd23);
  endfunction

  // Divide/modulus by zero: opcodes 3/4 divide by B, opcodes 6/7 divide by A.
  function automatic logic div_by_zero(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    logic z;
    case (op)
      5'd3, 5'd4: z = (b == 32'd0);
      5'd6, 5'd7: z = (a == 32'd0);
      default:    z = 1'b0;
    endcase
    return z;
  endfunction

  // Round-robin search upward from rr_ptr+1 and selection of the winner's operands.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = 3'd0;
    cand_s      = 4'd0;
    valid8_s    = 8'(bus.req_valid);
    for (int i = 0; i < 8; i++) begin
      op_arr_s[i] = 5'd0;
      a_arr_s[i]  = 32'd0;
      b_arr_s[i]  = 32'd0;
    end
    for (int i = 0; i < NREQ; i++) begin
      op_arr_s[i] = bus.req_opcode[5*i +: 5];
      a_arr_s[i]  = bus.req_a[32*i +: 32];
      b_arr_s[i]  = bus.req_b[32*i +: 32];
    end
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = {1'b0, rr_ptr_r} + 4'(k);
      if (cand_s >= 4'(NREQ)) begin
        cand_s = cand_s - 4'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_any_s && valid8_s[cand_s[IDW-1:0]]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_s[IDW-1:0];
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    oh8_s          = 8'd1 << grant_idx_s;
    grant_onehot_s = oh8_s[NREQ-1:0];
    sel_op_s       = op_arr_s[grant_idx_s];
    sel_a_s        = a_arr_s[grant_idx_s];
    sel_b_s        = b_arr_s[grant_idx_s];
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      rr_ptr_r     <= IDW'(NREQ - 1);
      cnt_r        <= 8'd0;
      req_ready_r  <= '0;
      alu_en_r     <= 1'b0;
      alu_opcode_r <= 5'd0;
      alu_in1_r    <= 32'd0;
      alu_in2_r    <= 32'd0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 3'd0;
      rsp_result_r <= 32'd0;
      rsp_err_r    <= 1'b0;
    end else begin
      req_ready_r <= '0;
      case (state_r)
        IDLE: begin
          if (grant_any_s) begin
            req_ready_r <= grant_onehot_s;
            rr_ptr_r    <= grant_idx_s;
            rsp_id_r    <= grant_idx_s;
            if (op_illegal(sel_op_s)) begin
              rsp_err_r    <= 1'b1;
              rsp_result_r <= 32'd0;
              rsp_valid_r  <= 1'b1;
              state_r      <= RESP;
            end else if (div_by_zero(sel_op_s, sel_a_s, sel_b_s)) begin
              rsp_err_r    <= 1'b1;
              rsp_result_r <= 32'hFFFF_FFFF;
              rsp_valid_r  <= 1'b1;
              state_r      <= RESP;
            end else begin
              alu_en_r     <= 1'b1;
              alu_opcode_r <= sel_op_s;
              alu_in1_r    <= sel_a_s;
              alu_in2_r    <= sel_b_s;
              cnt_r        <= exec_cycles(sel_op_s);
              state_r      <= EXEC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          if (cnt_r == 8'd0) begin
            rsp_result_r <= bus.alu_result;
            rsp_err_r    <= 1'b0;
            rsp_valid_r  <= 1'b1;
            alu_en_r     <= 1'b0;
            alu_opcode_r <= 5'd0;
            alu_in1_r    <= 32'd0;
            alu_in2_r    <= 32'd0;
            state_r      <= RESP;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          alu_en_r     <= 1'b0;
          alu_opcode_r <= 5'd0;
          alu_in1_r    <= 32'd0;
          alu_in2_r    <= 32'd0;
          rsp_valid_r  <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.alu_en     = alu_en_r;
  assign bus.alu_opcode = alu_opcode_r;
  assign bus.alu_in1    = alu_in1_r;
  assign bus.alu_in2    = alu_in2_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_err    = rsp_err_r;
endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one 32-bit, 5-bit-opcode ALU between NREQ requesters using round-robin arbitration and per-request valid/ready handshakes.
- Sequences each accepted operation over a fixed, opcode-dependent number of cycles, then captures the ALU result.
- Returns the result with the requester ID on a single response channel that has backpressure.
- Sits between the execution clients and the ALU datapath. It drives the ALU's enable, opcode and operand inputs and samples its result.

Parameters:
- NREQ, 4, number of requesters; range 2..8
- MUL_LAT, 2, EXEC cycles for opcode 2 (multiply)
- DIV_LAT, 4, EXEC cycles for opcodes 3, 4, 6, 7 (divide/modulus)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  one-hot grant/accept pulse
- req_opcode  in  5*NREQ  opcode of requester i, at bits [5i+4:5i]
- req_a  in  32*NREQ  operand in1 of requester i
- req_b  in  32*NREQ  operand in2 of requester i
- alu_en  out  1  ALU enable
- alu_opcode  out  5  ALU opcode
- alu_in1  out  32  ALU operand 1
- alu_in2  out  32  ALU operand 2
- alu_result  in  32  ALU result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer ready
- rsp_id  out  3  index of the requester that owns the response
- rsp_result  out  32  captured result
- rsp_err  out  1  error flag: illegal opcode or divide-by-zero

Behaviour:
- Reset values: all outputs 0; state=IDLE; rr_ptr=NREQ-1, so requester 0 has highest priority after reset.
- Reset mid-operation: aborts immediately; no response is generated and the in-flight request is lost.
- IDLE state:
  - If any req_valid is set, grant the first set bit searching upward from rr_ptr+1, modulo NREQ.
  - req_ready[g]=1 for exactly this cycle. Opcode, A and B are latched and g is latched as the ID.
  - rr_ptr<=g.
  - No req_ready is asserted in any other state.
- Latency class:
  - Opcode 2: MUL_LAT cycles.
  - Opcodes 3, 4, 6, 7: DIV_LAT cycles.
  - Opcodes 0..23 otherwise: 1 cycle.
- Error classes (no EXEC state is entered; go straight to RESP):
  - Opcode >23: rsp_err=1, rsp_result=0.
  - Opcodes 3 or 4 with B==0, or opcodes 6 or 7 with A==0: rsp_err=1, rsp_result=32'hFFFF_FFFF.
- Otherwise, from IDLE go to EXEC with cnt=latency-1.
- EXEC state:
  - alu_en=1; alu_opcode, alu_in1 and alu_in2 are driven from the latched values and are stable for the whole of EXEC.
  - cnt decrements each cycle.
  - When cnt==0: rsp_result<=alu_result, rsp_err<=0, go to RESP.
- Outside EXEC: alu_en=0 and alu_opcode/alu_in1/alu_in2 are driven to 0.
- RESP state:
  - rsp_valid=1; rsp_id, rsp_result and rsp_err are held stable until rsp_ready=1.
  - On the cycle with rsp_valid and rsp_ready both 1, return to IDLE.
  - A new grant is possible on the next cycle.
- Minimum occupancy: 3 cycles per operation (IDLE grant, 1 EXEC, RESP with rsp_ready=1). There is no overlap between operations.
- req_valid deasserted by a non-granted requester: the request is simply not considered. Requesters hold valid and operands until they see ready.
- Simultaneous requests: only one is granted per IDLE cycle. The others wait.
- Fairness: a continuously requesting requester is served within NREQ grants.
- Unused bits of rsp_id (when NREQ<8) are 0.

Test Plan:
- Reset, then req_valid[1] with op 0, A=5, B=7; rsp_ready=1 → req_ready[1] pulses 1 cycle after valid. alu_en is high for exactly 1 cycle. rsp_valid 2 cycles after grant with rsp_id=1, rsp_result=12, rsp_err=0.
- All four requesters hold valid, op 8, rsp_ready=1 → grant order 0,1,2,3,0,… with one grant every 3 cycles. Each rsp_id matches its grant.
- Op 3, A=100, B=7 with DIV_LAT=4 → alu_en high for 4 cycles with constant operands. rsp_result=14.
- Op 3 with B=0, then op 25 → first response err=1, result FFFF_FFFF. Second response err=1, result 0. alu_en stays 0 for both.
- Hold rsp_ready=0 for 5 cycles during RESP while others request → rsp_* stable, no req_ready pulses. Release rsp_ready → next grant on the following cycle.
- Assert rst_n=0 during EXEC of a DIV op → all outputs 0 immediately. After release, requester 0 wins a simultaneous 0/3 request.
